ddr_hdr_writer: RTL and testbench
=================================

# ddr_hdr_writer

Event-header write master feeding the 64-bit header slave port of the DDR interconnect. It takes fixed-length event headers from an AXI4-Stream and writes each one as a single INCR burst into a ring of header slots in DDR. It tracks which slots are still unread and holds off writes when the ring is full. For every completed write it reports the slot number and the write status to the readout side.

## Interface
Parameters:
- `ADDR_W`, 40, DDR byte-address width.
- `HDR_BASE`, 40'h0, byte address of slot 0; must be aligned to `HDR_BEATS*8`.
- `HDR_BEATS`, 8, 64-bit beats per header; a power of 2, 2..256.
- `NUM_SLOTS`, 64, slots in the ring; a power of 2, at least 2.
- `MAX_OUT`, 4, maximum AW bursts awaiting B; a power of 2.

Ports:
- `aclk` in 1: clock.
- `areset` in 1: asynchronous, active-high reset.
- `s_hdr_tdata` in 64: header beat.
- `s_hdr_tvalid` in 1 / `s_hdr_tready` out 1 / `s_hdr_tlast` in 1: AXI4-Stream handshake.
- `slot_free_i` in 1: one-cycle pulse; readout has consumed the oldest used slot.
- `m_axi_hdr_awaddr` out `ADDR_W`: burst address.
- `m_axi_hdr_awlen` out 8: constant `HDR_BEATS-1`.
- `m_axi_hdr_awsize` / `m_axi_hdr_awburst` out 3/2: constant 3'b011 / 2'b01.
- `m_axi_hdr_awvalid` out 1 / `m_axi_hdr_awready` in 1.
- `m_axi_hdr_wdata` out 64 / `m_axi_hdr_wstrb` out 8: `wstrb` is constant 8'hFF.
- `m_axi_hdr_wlast` out 1 / `m_axi_hdr_wvalid` out 1 / `m_axi_hdr_wready` in 1.
- `m_axi_hdr_bresp` in 2 / `m_axi_hdr_bvalid` in 1 / `m_axi_hdr_bready` out 1.
- `done_o` out 1: one-cycle pulse per B response.
- `done_slot_o` out `log2(NUM_SLOTS)`: slot written; valid with `done_o`.
- `done_err_o` out 1: high with `done_o` when `bresp != OKAY`.
- `len_err_o` out 1: one-cycle pulse on a `tlast` mismatch.
- `free_err_o` out 1: one-cycle pulse when `slot_free_i` arrives with no slot used.
- `slots_used_o` out `log2(NUM_SLOTS)+1`: current ring occupancy.

The AR and R channels are not implemented; the wrapper ties them off. AWID is always 0.

## Operation
- State machine: IDLE → ADDR → DATA → IDLE.
- IDLE → ADDR when all three hold: `s_hdr_tvalid=1`, `slots_used < NUM_SLOTS`, `outstanding < MAX_OUT`.
- On entry to ADDR:
  - `awaddr = HDR_BASE + wr_slot*HDR_BEATS*8`.
  - `awvalid` is held until `awready`.
  - On the handshake: `wr_slot` increments modulo `NUM_SLOTS`, `slots_used` +1, `outstanding` +1, and `wr_slot` is pushed into the slot FIFO; state moves to DATA.
- DATA is a combinational pass-through:
  - `wdata=tdata`, `wvalid=tvalid`, `tready=wready`.
  - `wlast` is high when `beat_cnt == HDR_BEATS-1`.
  - `beat_cnt` increments on each W handshake; on the last beat it clears and the state returns to IDLE.
  - `tready` is 0 outside DATA.
- `tlast` does not control framing; the beat count alone defines a header. `len_err_o` pulses on the last-beat handshake if `tlast=0`, or on any earlier beat if `tlast=1`.
- B channel:
  - `bready=1` whenever out of reset.
  - On `bvalid`: pop the slot FIFO to `done_slot_o`, pulse `done_o`, set `done_err_o = (bresp != 0)`, and decrement `outstanding`.
  - The single AWID guarantees in-order B responses, so FIFO order is correct.
- Slot release:
  - `slot_free_i` decrements `slots_used`.
  - If `slot_free_i` coincides with an AW handshake, `slots_used` is unchanged.
  - If `slot_free_i` arrives with `slots_used==0`, the count stays 0 and `free_err_o` pulses.
- `outstanding` obeys the same simultaneous-event rule: AW handshake and `bvalid` in the same cycle leave it unchanged.

## Timing
- Reset values: state IDLE; `wr_slot`, `slots_used`, `outstanding` and `beat_cnt` = 0; FIFO empty.
- Reset values of outputs: `awvalid`, `wvalid`, `tready`, `bready`, `done_o`, `done_err_o`, `len_err_o`, `free_err_o` = 0; `awaddr = HDR_BASE`.
- `awvalid` rises 1 cycle after `tvalid` is seen in IDLE with credit available.
- First W beat can complete in the cycle after the AW handshake.
- Minimum burst period is `HDR_BEATS+2` cycles.
- `done_o` is registered: 1 cycle after the `bvalid` handshake.
- `len_err_o` and `free_err_o` are registered: 1 cycle after the causing event.
- Reset mid-burst abandons the burst; the interconnect is reset together with this block.

## Structure
- Shared package `ddr_hdr_pkg`: `AXI_SIZE_8B`, `AXI_BURST_INCR`, `AXI_RESP_OKAY`, and the state enum.
- One sub-module: `ddr_hdr_slot_fifo`, a `MAX_OUT`-deep, `log2(NUM_SLOTS)`-wide register FIFO with push/pop and full/empty flags.

## Test plan
- Single 8-beat header, `awready` and `wready` always 1 → `awaddr = HDR_BASE`, `awlen = 7`, `wlast` on beat 8; `done_o` with slot 0 and `done_err_o = 0`.
- 65 headers with `NUM_SLOTS=64` and no `slot_free_i` → 64 bursts; the 65th stalls with `tready = 0`. One `slot_free_i` → the 65th writes slot 0 at `HDR_BASE`.
- Bvalid withheld → exactly 4 AW handshakes, then `awvalid` stays low; releasing B resumes writing, and `done_slot_o` reports 0, 1, 2, 3 in order.
- `tlast` on beat 5 of 8 → `len_err_o` pulses once; the burst still carries 8 beats.
- `bresp = 2'b10` on the second burst → `done_err_o = 1` with `done_slot_o = 1`.
- `slot_free_i` in the same cycle as an AW handshake → `slots_used_o` unchanged. `slot_free_i` at `slots_used = 0` → `free_err_o` pulses and occupancy stays 0.

Source files
------------

// File: rtl/ddr_hdr_pkg.sv
// Shared AXI encodings and writer state enum for the DDR header write path.
// Constants only; no latency or backpressure of its own.
package ddr_hdr_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/ddr_hdr_slot_fifo.sv
// Register FIFO of slot numbers for bursts awaiting B; pop data is the head, same-cycle.
// Push while full and pop while empty are ignored; the writer's credit check keeps it from overflowing.
module ddr_hdr_slot_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_hdr_writer.sv
// Writes each fixed-length stream header as one INCR burst into a DDR slot ring; AW one cycle after tvalid, W is a pass-through.
// Stalls the stream (tready=0) when the ring is full or MAX_OUT bursts await B; done/error pulses are registered.
module ddr_hdr_writer
    import ddr_hdr_pkg::*;
#(
    parameter int                 ADDR_W    = 40,
    parameter logic [ADDR_W-1:0]  HDR_BASE  = 40'h0,
    parameter int                 HDR_BEATS = 8,
    parameter int                 NUM_SLOTS = 64,
    parameter int                 MAX_OUT   = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [63:0]                   s_hdr_tdata,
    input  logic                          s_hdr_tvalid,
    output logic                          s_hdr_tready,
    input  logic                          s_hdr_tlast,
    input  logic                          slot_free_i,
    output logic [ADDR_W-1:0]             m_axi_hdr_awaddr,
    output logic [7:0]                    m_axi_hdr_awlen,
    output logic [2:0]                    m_axi_hdr_awsize,
    output logic [1:0]                    m_axi_hdr_awburst,
    output logic                          m_axi_hdr_awvalid,
    input  logic                          m_axi_hdr_awready,
    output logic [63:0]                   m_axi_hdr_wdata,
    output logic [7:0]                    m_axi_hdr_wstrb,
    output logic                          m_axi_hdr_wlast,
    output logic                          m_axi_hdr_wvalid,
    input  logic                          m_axi_hdr_wready,
    input  logic [1:0]                    m_axi_hdr_bresp,
    input  logic                          m_axi_hdr_bvalid,
    output logic                          m_axi_hdr_bready,
    output logic                          done_o,
    output logic [$clog2(NUM_SLOTS)-1:0]  done_slot_o,
    output logic                          done_err_o,
    output logic                          len_err_o,
    output logic                          free_err_o,
    output logic [$clog2(NUM_SLOTS):0]    slots_used_o
);
    localparam int SW     = $clog2(NUM_SLOTS);
    localparam int UW     = SW + 1;
    localparam int OW     = $clog2(MAX_OUT) + 1;
    localparam int BW     = $clog2(HDR_BEATS);
    localparam int OFF_SH = BW + 3;

    state_t             r_state;
    logic [SW-1:0]      r_wr_slot;
    logic [UW-1:0]      r_slots_used;
    logic [OW-1:0]      r_outstanding;
    logic [BW-1:0]      r_beat_cnt;
    logic               r_awvalid;
    logic [ADDR_W-1:0]  r_awaddr;
    logic               r_bready;
    logic               r_done;
    logic [SW-1:0]      r_done_slot;
    logic               r_done_err;
    logic               r_len_err;
    logic               r_free_err;

    logic               w_aw_hs;
    logic               w_in_data;
    logic               w_w_hs;
    logic               w_last_beat;
    logic               w_b_hs;
    logic               w_credit;
    logic [ADDR_W-1:0]  w_slot_addr;
    logic [SW-1:0]      w_fifo_dat;
    logic               w_fifo_full;
    logic               w_fifo_empty;

    assign w_aw_hs     = r_awvalid && m_axi_hdr_awready;
    assign w_in_data   = (r_state == ST_DATA);
    assign w_w_hs      = w_in_data && s_hdr_tvalid && m_axi_hdr_wready;
    assign w_last_beat = (r_beat_cnt == BW'(HDR_BEATS - 1));
    assign w_b_hs      = m_axi_hdr_bvalid && r_bready;
    assign w_credit    = (r_slots_used < UW'(NUM_SLOTS)) && (r_outstanding < OW'(MAX_OUT))
                         && !w_fifo_full;
    assign w_slot_addr = HDR_BASE + (ADDR_W'(r_wr_slot) << OFF_SH);

    assign m_axi_hdr_awaddr  = r_awaddr;
    assign m_axi_hdr_awlen   = 8'(HDR_BEATS - 1);
    assign m_axi_hdr_awsize  = AXI_SIZE_8B;
    assign m_axi_hdr_awburst = AXI_BURST_INCR;
    assign m_axi_hdr_awvalid = r_awvalid;
    assign m_axi_hdr_wdata   = s_hdr_tdata;
    assign m_axi_hdr_wstrb   = 8'hFF;
    assign m_axi_hdr_wlast   = w_in_data && w_last_beat;
    assign m_axi_hdr_wvalid  = w_in_data && s_hdr_tvalid;
    assign s_hdr_tready      = w_in_data && m_axi_hdr_wready;
    assign m_axi_hdr_bready  = r_bready;
    assign done_o            = r_done;
    assign done_slot_o       = r_done_slot;
    assign done_err_o        = r_done_err;
    assign len_err_o         = r_len_err;
    assign free_err_o        = r_free_err;
    assign slots_used_o      = r_slots_used;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_wr_slot  <= '0;
            r_beat_cnt <= '0;
            r_awvalid  <= 1'b0;
            r_awaddr   <= HDR_BASE;
            r_len_err  <= 1'b0;
        end else begin
            // tlast is only checked, never used for framing
            r_len_err <= w_w_hs && (w_last_beat != s_hdr_tlast);
            case (r_state)
                ST_IDLE: begin
                    if (s_hdr_tvalid && w_credit) begin
                        r_awaddr  <= w_slot_addr;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_hdr_awready) begin
                        r_awvalid <= 1'b0;
                        r_wr_slot <= r_wr_slot + SW'(1);
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_slots_used  <= '0;
            r_outstanding <= '0;
            r_free_err    <= 1'b0;
            r_bready      <= 1'b0;
            r_done        <= 1'b0;
            r_done_slot   <= '0;
            r_done_err    <= 1'b0;
        end else begin
            r_bready   <= 1'b1;
            r_free_err <= slot_free_i && !w_aw_hs && (r_slots_used == '0);
            // A claim and a release in the same cycle cancel out
            case ({w_aw_hs, slot_free_i})
                2'b10: r_slots_used <= r_slots_used + UW'(1);
                2'b01: if (r_slots_used != '0) r_slots_used <= r_slots_used - UW'(1);
                default: r_slots_used <= r_slots_used;
            endcase
            case ({w_aw_hs, w_b_hs})
                2'b10: r_outstanding <= r_outstanding + OW'(1);
                2'b01: if (r_outstanding != '0) r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            r_done     <= w_b_hs;
            r_done_err <= w_b_hs && (m_axi_hdr_bresp != AXI_RESP_OKAY);
            if (w_b_hs && !w_fifo_empty) begin
                r_done_slot <= w_fifo_dat;
            end
        end
    end

    ddr_hdr_slot_fifo #(
        .DEPTH (MAX_OUT),
        .W     (SW)
    ) u_slot_fifo (
        .clk      (aclk),
        .rst      (areset),
        .push     (w_aw_hs),
        .push_dat (r_wr_slot),
        .pop      (w_b_hs),
        .pop_dat  (w_fifo_dat),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

endmodule

// File: tb/tb_ddr_hdr_writer.sv
// Directed bench for ddr_hdr_writer: AXI slave model on negedge, stream driver in the main process.
module tb_ddr_hdr_writer;
    localparam logic [39:0] HDR_BASE = 40'h00_8000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] s_hdr_tdata;
    logic        s_hdr_tvalid;
    logic        s_hdr_tready;
    logic        s_hdr_tlast;
    logic        slot_free_i;
    logic [39:0] m_axi_hdr_awaddr;
    logic [7:0]  m_axi_hdr_awlen;
    logic [2:0]  m_axi_hdr_awsize;
    logic [1:0]  m_axi_hdr_awburst;
    logic        m_axi_hdr_awvalid;
    logic        m_axi_hdr_awready;
    logic [63:0] m_axi_hdr_wdata;
    logic [7:0]  m_axi_hdr_wstrb;
    logic        m_axi_hdr_wlast;
    logic        m_axi_hdr_wvalid;
    logic        m_axi_hdr_wready;
    logic [1:0]  m_axi_hdr_bresp;
    logic        m_axi_hdr_bvalid;
    logic        m_axi_hdr_bready;
    logic        done_o;
    logic [5:0]  done_slot_o;
    logic        done_err_o;
    logic        len_err_o;
    logic        free_err_o;
    logic [6:0]  slots_used_o;

    int n_chk  = 0;
    int n_fail = 0;

    // written by the main process only
    int          aw_base   = 0;
    int          done_base = 0;
    int          err_idx   = -1;
    bit          b_en      = 1'b1;
    logic [63:0] cur_d0    = '0;

    // written by the slave model only
    int          aw_cnt       = 0;
    logic [39:0] last_awaddr  = '0;
    int          beat         = 0;
    int          w_beats      = 0;
    int          w_done_cnt   = 0;
    int          b_issued     = 0;
    int          len_err_cnt  = 0;
    int          free_err_cnt = 0;
    logic [5:0]  done_slot_q[$];
    logic        done_err_q[$];

    always #5 aclk = ~aclk;

    ddr_hdr_writer #(
        .ADDR_W    (40),
        .HDR_BASE  (HDR_BASE),
        .HDR_BEATS (8),
        .NUM_SLOTS (64),
        .MAX_OUT   (4)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_hdr_tdata       (s_hdr_tdata),
        .s_hdr_tvalid      (s_hdr_tvalid),
        .s_hdr_tready      (s_hdr_tready),
        .s_hdr_tlast       (s_hdr_tlast),
        .slot_free_i       (slot_free_i),
        .m_axi_hdr_awaddr  (m_axi_hdr_awaddr),
        .m_axi_hdr_awlen   (m_axi_hdr_awlen),
        .m_axi_hdr_awsize  (m_axi_hdr_awsize),
        .m_axi_hdr_awburst (m_axi_hdr_awburst),
        .m_axi_hdr_awvalid (m_axi_hdr_awvalid),
        .m_axi_hdr_awready (m_axi_hdr_awready),
        .m_axi_hdr_wdata   (m_axi_hdr_wdata),
        .m_axi_hdr_wstrb   (m_axi_hdr_wstrb),
        .m_axi_hdr_wlast   (m_axi_hdr_wlast),
        .m_axi_hdr_wvalid  (m_axi_hdr_wvalid),
        .m_axi_hdr_wready  (m_axi_hdr_wready),
        .m_axi_hdr_bresp   (m_axi_hdr_bresp),
        .m_axi_hdr_bvalid  (m_axi_hdr_bvalid),
        .m_axi_hdr_bready  (m_axi_hdr_bready),
        .done_o            (done_o),
        .done_slot_o       (done_slot_o),
        .done_err_o        (done_err_o),
        .len_err_o         (len_err_o),
        .free_err_o        (free_err_o),
        .slots_used_o      (slots_used_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: B responses follow completed bursts in order; sampled 2ns after negedge.
    initial begin
        m_axi_hdr_bvalid = 1'b0;
        m_axi_hdr_bresp  = 2'b00;
        forever begin
            @(negedge aclk);
            #2;
            m_axi_hdr_bvalid = b_en && (w_done_cnt > b_issued);
            m_axi_hdr_bresp  = (b_issued == err_idx) ? 2'b10 : 2'b00;
            if (m_axi_hdr_awvalid && m_axi_hdr_awready) begin
                chk("awaddr", m_axi_hdr_awaddr,
                    64'(HDR_BASE + 40'(((aw_cnt - aw_base) % 64) * 64)));
                last_awaddr = m_axi_hdr_awaddr;
                aw_cnt++;
            end
            if (m_axi_hdr_wvalid && m_axi_hdr_wready) begin
                chk("wlast", m_axi_hdr_wlast, beat == 7);
                chk("wdata", m_axi_hdr_wdata, cur_d0 + 64'(beat));
                w_beats++;
                if (beat == 7) begin
                    beat = 0;
                    w_done_cnt++;
                end else begin
                    beat++;
                end
            end
            if (m_axi_hdr_bvalid && m_axi_hdr_bready) b_issued++;
            if (done_o) begin
                done_slot_q.push_back(done_slot_o);
                done_err_q.push_back(done_err_o);
            end
            if (len_err_o) len_err_cnt++;
            if (free_err_o) free_err_cnt++;
        end
    end

    task automatic send_hdr(input logic [63:0] d0, input logic [7:0] lmask);
        cur_d0 = d0;
        for (int b = 0; b < 8; b++) begin
            int w;
            w = 0;
            s_hdr_tvalid = 1'b1;
            s_hdr_tdata  = d0 + 64'(b);
            s_hdr_tlast  = lmask[b];
            #1;
            while (!s_hdr_tready && w < 60) begin
                @(negedge aclk);
                #1;
                w++;
            end
            if (!s_hdr_tready) begin
                chk("tready_timeout", s_hdr_tready, 1);
                s_hdr_tvalid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        s_hdr_tvalid = 1'b0;
        s_hdr_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int w;
        w = 0;
        while ((done_slot_q.size() - done_base) < n && w < 400) begin
            @(negedge aclk);
            w++;
        end
        chk("done_count", done_slot_q.size() - done_base, n);
    endtask

    task automatic pulse_free();
        slot_free_i = 1'b1;
        @(negedge aclk);
        slot_free_i = 1'b0;
        @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset    = 1'b0;
        aw_base   = aw_cnt;
        done_base = done_slot_q.size();
        @(negedge aclk);
        chk("rst_slots_used", slots_used_o, 0);
    endtask

    task automatic watch_stall(input string tag);
        bit seen;
        seen = 1'b0;
        repeat (20) begin
            @(negedge aclk);
            #1;
            seen = seen | m_axi_hdr_awvalid | s_hdr_tready;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        areset            = 1'b1;
        s_hdr_tdata       = '0;
        s_hdr_tvalid      = 1'b0;
        s_hdr_tlast       = 1'b0;
        slot_free_i       = 1'b0;
        m_axi_hdr_awready = 1'b1;
        m_axi_hdr_wready  = 1'b1;

        @(negedge aclk);
        #2;
        chk("rst_awvalid", m_axi_hdr_awvalid, 0);
        chk("rst_wvalid", m_axi_hdr_wvalid, 0);
        chk("rst_tready", s_hdr_tready, 0);
        chk("rst_bready", m_axi_hdr_bready, 0);
        chk("rst_pulses", {done_o, done_err_o, len_err_o, free_err_o}, 4'b0000);
        chk("rst_awaddr", m_axi_hdr_awaddr, HDR_BASE);
        chk("rst_used", slots_used_o, 0);
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        chk("bready_up", m_axi_hdr_bready, 1);
        chk("aw_consts", {m_axi_hdr_awlen, m_axi_hdr_awsize, m_axi_hdr_awburst},
            {8'd7, 3'b011, 2'b01});
        chk("wstrb", m_axi_hdr_wstrb, 8'hFF);

        // single header
        send_hdr(64'hA000, 8'h80);
        wait_done(1);
        chk("t1_slot", done_slot_q[done_base], 0);
        chk("t1_err", done_err_q[done_base], 0);
        chk("t1_addr", last_awaddr, HDR_BASE);
        chk("t1_beats", w_beats, 8);
        chk("t1_used", slots_used_o, 1);

        // early tlast on beat 5 plus SLVERR on the second burst
        err_idx = b_issued;
        send_hdr(64'hB000, 8'h90);
        wait_done(2);
        err_idx = -1;
        chk("len_err_once", len_err_cnt, 1);
        chk("t2_beats", w_beats, 16);
        chk("t2_slot", done_slot_q[done_base + 1], 1);
        chk("t2_err", done_err_q[done_base + 1], 1);

        // release both slots, then one spurious release
        pulse_free();
        pulse_free();
        chk("freed_used", slots_used_o, 0);
        pulse_free();
        @(negedge aclk);
        chk("free_err_cnt", free_err_cnt, 1);
        chk("free_err_used", slots_used_o, 0);

        // outstanding limit with B withheld
        do_reset();
        b_en = 1'b0;
        for (int i = 0; i < 4; i++) send_hdr(64'hC000 + 64'(i * 256), 8'h80);
        s_hdr_tvalid = 1'b1;
        s_hdr_tdata  = 64'hC400;
        watch_stall("out_stall");
        chk("out_aw_cnt", aw_cnt - aw_base, 4);
        chk("out_no_done", done_slot_q.size() - done_base, 0);
        b_en = 1'b1;
        send_hdr(64'hC400, 8'h80);
        wait_done(5);
        for (int i = 0; i < 5; i++) chk("out_order", done_slot_q[done_base + i], 6'(i));

        // ring full at 64 slots
        do_reset();
        for (int i = 0; i < 64; i++) send_hdr(64'h10000 + 64'(i * 256), 8'h80);
        wait_done(64);
        chk("full_used", slots_used_o, 64);
        s_hdr_tvalid = 1'b1;
        s_hdr_tdata  = 64'hD000;
        watch_stall("full_stall");
        chk("full_aw_cnt", aw_cnt - aw_base, 64);
        pulse_free();
        #1;
        chk("full_freed", slots_used_o, 63);
        send_hdr(64'hD000, 8'h80);
        wait_done(65);
        chk("wrap_slot", done_slot_q[done_base + 64], 0);
        chk("wrap_addr", last_awaddr, HDR_BASE);
        chk("wrap_used", slots_used_o, 64);

        // release coinciding with an AW handshake
        pulse_free();
        pulse_free();
        chk("pre_sim_used", slots_used_o, 62);
        m_axi_hdr_awready = 1'b0;
        cur_d0            = 64'hE000;
        s_hdr_tdata       = 64'hE000;
        s_hdr_tvalid      = 1'b1;
        begin
            int w;
            w = 0;
            do begin
                @(negedge aclk);
                #1;
                w++;
            end while (!m_axi_hdr_awvalid && w < 20);
        end
        chk("aw_held", m_axi_hdr_awvalid, 1);
        m_axi_hdr_awready = 1'b1;
        slot_free_i       = 1'b1;
        @(negedge aclk);
        slot_free_i = 1'b0;
        #1;
        chk("sim_used", slots_used_o, 62);
        chk("sim_aw_done", m_axi_hdr_awvalid, 0);
        send_hdr(64'hE000, 8'h80);
        wait_done(66);
        chk("sim_slot", done_slot_q[done_base + 65], 1);
        chk("sim_used_end", slots_used_o, 62);
        chk("sim_no_free_err", free_err_cnt, 1);
        chk("final_len_err", len_err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
